// File: rtl/tetris_pkg.sv
// Shared Tetris display types, piece colours and screen geometry.
// Used by next_piece_preview and its shift-register sub-module.
package tetris_pkg;

  typedef enum logic [2:0] {
    BLK_I    = 3'd0,
    BLK_L    = 3'd1,
    BLK_J    = 3'd2,
    BLK_O    = 3'd3,
    BLK_S    = 3'd4,
    BLK_T    = 3'd5,
    BLK_Z    = 3'd6,
    BLK_NONE = 3'd7
  } block_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // RGB444, indexed by block_t; NONE renders black.
  localparam logic [11:0] COLOR_LUT [0:7] = '{
    12'h0FF,
    12'hF80,
    12'h00F,
    12'hFF0,
    12'h0F0,
    12'hA0F,
    12'hF00,
    12'h000
  };

  localparam logic [11:0] BORDER_COLOR = 12'hFFF;

  function automatic logic scale_ok(input int s);
    return (s == 1) || (s == 2) || (s == 4) || (s == 8);
  endfunction

endpackage

// File: rtl/preview_shifter.sv
// Serializes one 8-bit sprite row into 8*SCALE screen pixels.
// The FSM state is exported on busy (1 = SHIFT).
module preview_shifter
  import tetris_pkg::*;
#(
  parameter int SCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       pix_en,
  input  logic [7:0] data,
  output logic       lit,
  output logic       busy
);

  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  shift_state_t  state;
  shift_state_t  next_state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [SW-1:0] scale_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (load) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (pix_en && (bit_cnt == 3'd0) && (scale_cnt == '0)) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    lit  = 1'b0;
    busy = (state == ST_SHIFT);
    case (state)
      ST_IDLE:  lit = load & data[7];
      ST_SHIFT: lit = shreg[7];
      default:  lit = 1'b0;
    endcase
  end

  // The load cycle already shows the first screen pixel of sprite pixel 0,
  // so the counters start one screen pixel further on to keep 8*SCALE total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      scale_cnt <= '0;
    end else if ((state == ST_IDLE) && load) begin
      if (SCALE == 1) begin
        shreg     <= data << 1;
        bit_cnt   <= 3'd6;
        scale_cnt <= '0;
      end else begin
        shreg     <= data;
        bit_cnt   <= 3'd7;
        scale_cnt <= SW'(SCALE - 2);
      end
    end else if ((state == ST_SHIFT) && pix_en) begin
      if (scale_cnt == '0) begin
        shreg     <= shreg << 1;
        bit_cnt   <= bit_cnt - 3'd1;
        scale_cnt <= SW'(SCALE - 1);
      end else begin
        scale_cnt <= scale_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/next_piece_preview.sv
// "Next piece" preview layer: piece double-buffering, sprite ROM addressing and
// registered pixel output. Optional frame around the window: PREVIEW_BORDER_EN.
module next_piece_preview
  import tetris_pkg::*;
#(
  parameter int X0    = 480,
  parameter int Y0    = 64,
  parameter int SCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic [9:0]  pixel_row,
  input  logic [9:0]  pixel_column,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic [2:0]  next_block_in,
  input  logic        next_block_valid,
  output logic [2:0]  sprite_block,
  output logic [2:0]  sprite_row,
  input  logic [7:0]  sprite_pixels,
  output logic        preview_on,
  output logic [11:0] preview_color
);

  localparam int WIN      = 8 * SCALE;
  localparam int ROW_SHFT = $clog2(SCALE);

  if (!scale_ok(SCALE)) begin : g_bad_scale
    $error("next_piece_preview: SCALE must be 1, 2, 4 or 8");
  end
  if (X0 + WIN > H_ACTIVE) begin : g_bad_x
    $error("next_piece_preview: preview window exceeds screen width");
  end
  if (Y0 + WIN > V_ACTIVE) begin : g_bad_y
    $error("next_piece_preview: preview window exceeds screen height");
  end

  block_t     pending;
  block_t     active;
  logic [9:0] rel_y;
  logic       in_rows;
  logic       load;
  logic       lit;
  logic       busy;

  // Strobes are system-clock events and are captured on any cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= BLK_NONE;
      active  <= BLK_NONE;
    end else begin
      if (next_block_valid) pending <= block_t'(next_block_in);
      if (frame_start) active <= next_block_valid ? block_t'(next_block_in) : pending;
    end
  end

  assign sprite_block = active;
  assign rel_y        = pixel_row - 10'(Y0);
  assign in_rows      = (rel_y < 10'(WIN));
  assign sprite_row   = 3'(rel_y >> ROW_SHFT);
  assign load         = pix_en & in_rows & (pixel_column == 10'(X0)) &
                        (active != BLK_NONE) & ~busy;

  preview_shifter #(
    .SCALE (SCALE)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .pix_en (pix_en),
    .data   (sprite_pixels),
    .lit    (lit),
    .busy   (busy)
  );

`ifdef PREVIEW_BORDER_EN
  logic [9:0] rel_x;
  logic       edge_x;
  logic       edge_y;
  logic       span_x;
  logic       span_y;
  logic       border;

  // rel == 10'h3FF is the column/row just before the window (-1).
  assign rel_x  = pixel_column - 10'(X0);
  assign edge_x = (rel_x == 10'h3FF) || (rel_x == 10'(WIN));
  assign edge_y = (rel_y == 10'h3FF) || (rel_y == 10'(WIN));
  assign span_x = (rel_x == 10'h3FF) || (rel_x <= 10'(WIN));
  assign span_y = (rel_y == 10'h3FF) || (rel_y <= 10'(WIN));
  assign border = (edge_y & span_x) | (edge_x & span_y);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preview_on    <= 1'b0;
      preview_color <= 12'h000;
    end else if (pix_en) begin
`ifdef PREVIEW_BORDER_EN
      if (border) begin
        preview_on    <= video_on;
        preview_color <= BORDER_COLOR;
      end else begin
        preview_on    <= video_on & lit;
        preview_color <= COLOR_LUT[active];
      end
`else
      preview_on    <= video_on & lit;
      preview_color <= COLOR_LUT[active];
`endif
    end
  end

endmodule

// File: tb/tb_next_piece_preview.sv
// Bench for next_piece_preview: directed vector table, hand-written corner
// sequences and randomized rows checked against a behavioural picture model.
module tb_next_piece_preview;
  import tetris_pkg::*;

  localparam int X0    = 480;
  localparam int Y0    = 64;
  localparam int SCALE = 4;
  localparam int WIN   = 8 * SCALE;
  localparam int NONE  = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic [9:0]  pixel_row;
  logic [9:0]  pixel_column;
  logic        video_on;
  logic        frame_start;
  logic [2:0]  next_block_in;
  logic        next_block_valid;
  logic [2:0]  sprite_block;
  logic [2:0]  sprite_row;
  logic [7:0]  sprite_pixels;
  logic        preview_on;
  logic [11:0] preview_color;

  always #5 clk = ~clk;

  next_piece_preview #(.X0(X0), .Y0(Y0), .SCALE(SCALE)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pix_en           (pix_en),
    .pixel_row        (pixel_row),
    .pixel_column     (pixel_column),
    .video_on         (video_on),
    .frame_start      (frame_start),
    .next_block_in    (next_block_in),
    .next_block_valid (next_block_valid),
    .sprite_block     (sprite_block),
    .sprite_row       (sprite_row),
    .sprite_pixels    (sprite_pixels),
    .preview_on       (preview_on),
    .preview_color    (preview_color)
  );

  // Sprite ROM: each tetromino cell is 2x2 sprite pixels, shape in rows 2..5.
  function automatic logic [7:0] rom(input logic [2:0] b, input logic [2:0] r);
    logic hi;
    logic lo;
    hi = (r == 3'd2) || (r == 3'd3);
    lo = (r == 3'd4) || (r == 3'd5);
    case (b)
      3'd0:    return lo ? 8'hFF : 8'h00;
      3'd1:    return hi ? 8'hFC : (lo ? 8'hC0 : 8'h00);
      3'd2:    return hi ? 8'hFC : (lo ? 8'h0C : 8'h00);
      3'd3:    return (hi || lo) ? 8'h3C : 8'h00;
      3'd4:    return hi ? 8'h3C : (lo ? 8'hF0 : 8'h00);
      3'd5:    return hi ? 8'hFC : (lo ? 8'h30 : 8'h00);
      3'd6:    return hi ? 8'hF0 : (lo ? 8'h3C : 8'h00);
      default: return 8'h00;
    endcase
  endfunction

  always_comb sprite_pixels = rom(sprite_block, sprite_row);

  // Reference state: which piece is queued and which is on screen.
  logic [2:0] m_pending;
  logic [2:0] m_active;

  function automatic logic model_lit(input int row, input int col);
    int ry;
    int rx;
    logic [7:0] d;
    ry = row - Y0;
    rx = col - X0;
    if (m_active == 3'd7) return 1'b0;
    if (ry < 0 || ry >= WIN || rx < 0 || rx >= WIN) return 1'b0;
    d = rom(m_active, 3'(ry / SCALE));
    return d[7 - rx / SCALE];
  endfunction

  function automatic logic model_border(input int row, input int col);
`ifdef PREVIEW_BORDER_EN
    int ry;
    int rx;
    logic ex, ey, sx, sy;
    ry = row - Y0;
    rx = col - X0;
    ex = (rx == -1) || (rx == WIN);
    ey = (ry == -1) || (ry == WIN);
    sx = (rx >= -1) && (rx <= WIN);
    sy = (ry >= -1) && (ry <= WIN);
    return (ey && sx) || (ex && sy);
`else
    return 1'b0;
`endif
  endfunction

  logic [12:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Present one pixel; table mode expects lit exactly inside [first,last].
  task automatic present(input int row, input int col, input logic von,
                         input logic use_model, input int first, input int last);
    logic        on_e;
    logic [11:0] color_e;
    logic [12:0] want;
    pixel_row    = 10'(row);
    pixel_column = 10'(col);
    video_on     = von;
    pix_en       = 1'b1;
    on_e    = use_model ? model_lit(row, col) : (col >= first && col <= last);
    on_e    = (on_e | model_border(row, col)) & von;
    color_e = model_border(row, col) ? BORDER_COLOR : COLOR_LUT[m_active];
    exp_q.push_back({on_e, color_e});
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    want = exp_q.pop_front();
    check($sformatf("pixel r%0d c%0d", row, col), {19'd0, preview_on, preview_color}, {19'd0, want});
    gap();
  endtask

  task automatic scan(input int row, input int c_lo, input int c_hi, input logic use_model,
                      input int first, input int last, input int voff_lo, input int voff_hi);
    for (int c = c_lo; c <= c_hi; c++)
      present(row, c, !(c >= voff_lo && c <= voff_hi), use_model, first, last);
  endtask

  task automatic strobe(input logic v, input logic [2:0] code, input logic f);
    next_block_in    = code;
    next_block_valid = v;
    frame_start      = f;
    pix_en           = 1'b1;
    pixel_row        = 10'd0;
    pixel_column     = 10'd0;
    video_on         = 1'b0;
    @(posedge clk);
    #1;
    next_block_valid = 1'b0;
    frame_start      = 1'b0;
    pix_en           = 1'b0;
    if (v && f) begin
      m_active  = code;
      m_pending = code;
    end else begin
      if (v) m_pending = code;
      if (f) m_active = m_pending;
    end
    gap();
  endtask

  typedef struct {
    logic [2:0] code;
    int         row;
    int         first;
    int         last;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{3'd3, 72, 488, 503};
    vecs[1]  = '{3'd0, 80, 480, 511};
    vecs[2]  = '{3'd0, 64, NONE, 0};
    vecs[3]  = '{3'd0, 79, NONE, 0};
    vecs[4]  = '{3'd5, 72, 480, 503};
    vecs[5]  = '{3'd6, 72, 480, 495};
    vecs[6]  = '{3'd6, 80, 488, 503};
    vecs[7]  = '{3'd1, 80, 480, 487};
    vecs[8]  = '{3'd2, 80, 496, 503};
    vecs[9]  = '{3'd4, 80, 480, 495};
    vecs[10] = '{3'd3, 87, 488, 503};
    vecs[11] = '{3'd3, 96, NONE, 0};

    rst_n = 1'b0;
    pix_en = 1'b0;
    pixel_row = '0;
    pixel_column = '0;
    video_on = 1'b0;
    frame_start = 1'b0;
    next_block_in = '0;
    next_block_valid = 1'b0;
    m_pending = 3'd7;
    m_active = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset preview_on", {31'd0, preview_on}, 32'd0);
    check("reset preview_color", {20'd0, preview_color}, 32'd0);
    check("reset sprite_block", {29'd0, sprite_block}, 32'd7);

    for (int i = 0; i < 12; i++) begin
      strobe(1'b1, vecs[i].code, 1'b1);
      check($sformatf("vec%0d sprite_block", i), {29'd0, sprite_block}, {29'd0, vecs[i].code});
      scan(vecs[i].row, 470, 520, 1'b0, vecs[i].first, vecs[i].last, -1, -2);
    end

    // Frame latch: a new code waits for frame_start.
    strobe(1'b1, 3'd5, 1'b1);
    scan(70, 470, 520, 1'b1, 0, 0, -1, -2);
    strobe(1'b1, 3'd6, 1'b0);
    check("latch sprite_block held", {29'd0, sprite_block}, 32'd5);
    scan(72, 470, 520, 1'b0, 480, 503, -1, -2);
    strobe(1'b0, 3'd0, 1'b1);
    check("latch sprite_block new", {29'd0, sprite_block}, 32'd6);
    scan(72, 470, 520, 1'b0, 480, 495, -1, -2);

    // Simultaneous strobes with code 7: nothing drawn.
    strobe(1'b1, 3'd7, 1'b1);
    check("bypass sprite_block", {29'd0, sprite_block}, 32'd7);
    scan(72, 470, 520, 1'b0, NONE, 0, -1, -2);
    scan(80, 470, 520, 1'b0, NONE, 0, -1, -2);

    // Reset in the middle of a lit run.
    strobe(1'b1, 3'd3, 1'b1);
    scan(72, 470, 490, 1'b0, 488, 503, -1, -2);
    #2;
    rst_n = 1'b0;
    m_pending = 3'd7;
    m_active = 3'd7;
    #1;
    check("async reset preview_on", {31'd0, preview_on}, 32'd0);
    check("async reset sprite_block", {29'd0, sprite_block}, 32'd7);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    strobe(1'b0, 3'd0, 1'b1);
    check("pending after reset", {29'd0, sprite_block}, 32'd7);
    strobe(1'b1, 3'd3, 1'b1);
    scan(72, 491, 520, 1'b0, NONE, 0, -1, -2);
    scan(72, 470, 520, 1'b0, 488, 503, -1, -2);

    // video_on low masks pixels while the row keeps shifting.
    scan(72, 470, 520, 1'b0, 488, 503, 488, 495);

`ifdef PREVIEW_BORDER_EN
    strobe(1'b1, 3'd7, 1'b1);
    scan(63, 470, 520, 1'b0, NONE, 0, -1, -2);
`endif

    for (int i = 0; i < 40; i++) begin
      int mode;
      int row;
      int vlo;
      int vhi;
      logic [2:0] code;
      mode = $urandom_range(0, 3);
      code = 3'($urandom_range(0, 7));
      case (mode)
        0: strobe(1'b1, code, 1'b1);
        1: begin
          strobe(1'b1, code, 1'b0);
          strobe(1'b0, 3'd0, 1'b1);
        end
        2: strobe(1'b1, code, 1'b0);
        default: strobe(1'b0, 3'd0, 1'b1);
      endcase
      row = $urandom_range(Y0 - 3, Y0 + WIN + 2);
      vlo = -1;
      vhi = -2;
      if ($urandom_range(0, 3) == 0) begin
        vlo = $urandom_range(X0, X0 + WIN);
        vhi = vlo + $urandom_range(0, 8);
      end
      scan(row, X0 - 6, X0 + WIN + 6, 1'b1, 0, 0, vlo, vhi);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
